// File: rtl/list_buffer_ctrl.sv
// Linked-list buffer controller: QUEUES FIFOs share one slot pool and next-pointer RAM.
// Slots are allocated lowest-free-first; a slot retired by a pop becomes allocatable next cycle.
module list_buffer_ctrl #(
    parameter int unsigned ENTRIES = 33,
    parameter int unsigned IDX_W   = 6,
    parameter int unsigned QUEUES  = 4,
    parameter int unsigned Q_W     = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [Q_W-1:0]    push_q,
    output logic [IDX_W-1:0]  push_idx,
    input  logic              pop_valid,
    output logic              pop_ready,
    input  logic [Q_W-1:0]    pop_q,
    output logic [IDX_W-1:0]  pop_idx,
    output logic [QUEUES-1:0] q_valid,
    output logic [IDX_W-1:0]  free_count,
    output logic              next_w_en,
    output logic [IDX_W-1:0]  next_w_addr,
    output logic [IDX_W-1:0]  next_w_data,
    output logic              next_r_en,
    output logic [IDX_W-1:0]  next_r_addr,
    input  logic [IDX_W-1:0]  next_r_data
);

    logic [ENTRIES-1:0] free_q, free_d;
    logic [QUEUES-1:0]  valid_q, valid_d;
    logic [IDX_W-1:0]   head_q [QUEUES];
    logic [IDX_W-1:0]   head_d [QUEUES];
    logic [IDX_W-1:0]   tail_q [QUEUES];
    logic [IDX_W-1:0]   tail_d [QUEUES];
    logic [IDX_W-1:0]   count_q, count_d;

    logic push_fire;
    logic pop_fire;
    logic pop_last;
    logic empty_same;
    logic [IDX_W-1:0] low_idx;

    // Lowest set bit of the free bitmap; scanning downward leaves the lowest hit.
    always_comb begin
        low_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign push_ready = |free_q;
    assign push_idx   = low_idx;
    assign pop_ready  = valid_q[pop_q];
    assign pop_idx    = head_q[pop_q];
    assign q_valid    = valid_q;
    assign free_count = count_q;

    assign push_fire  = push_valid & push_ready;
    assign pop_fire   = pop_valid & pop_ready;
    assign pop_last   = (head_q[pop_q] == tail_q[pop_q]);
    // Pop drains the last element of the queue being pushed: push restarts the list.
    assign empty_same = pop_fire & pop_last & push_fire & (push_q == pop_q);

    // Next-pointer RAM ports: link the new slot after the old tail, read the head's successor.
    always_comb begin
        next_w_en   = push_fire & valid_q[push_q] & ~empty_same;
        next_w_addr = tail_q[push_q];
        next_w_data = push_idx;
        next_r_en   = pop_fire;
        next_r_addr = head_q[pop_q];
    end

    // Next-state: apply the pop first, then the push so a restart overrides the drain.
    always_comb begin
        free_d  = free_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_fire) begin
            free_d[head_q[pop_q]] = 1'b1;
            if (pop_last) begin
                valid_d[pop_q] = 1'b0;
            end else begin
                head_d[pop_q] = next_r_data;
            end
        end
        if (push_fire) begin
            free_d[push_idx] = 1'b0;
            if (valid_q[push_q] && !empty_same) begin
                tail_d[push_q] = push_idx;
            end else begin
                head_d[push_q]  = push_idx;
                tail_d[push_q]  = push_idx;
                valid_d[push_q] = 1'b1;
            end
        end
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q - IDX_W'(1);
            2'b01:   count_d = count_q + IDX_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset; RAM contents are left untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            free_q  <= '1;
            valid_q <= '0;
            count_q <= IDX_W'(ENTRIES);
            for (int q = 0; q < int'(QUEUES); q++) begin
                head_q[q] <= '0;
                tail_q[q] <= '0;
            end
        end else begin
            free_q  <= free_d;
            valid_q <= valid_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: tb/tb_list_buffer_ctrl.sv
// Directed bench for list_buffer_ctrl with a behavioural next-pointer RAM.
module tb_list_buffer_ctrl;

    localparam int unsigned ENTRIES = 33;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned QUEUES  = 4;
    localparam int unsigned Q_W     = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              push_valid;
    logic              push_ready;
    logic [Q_W-1:0]    push_q;
    logic [IDX_W-1:0]  push_idx;
    logic              pop_valid;
    logic              pop_ready;
    logic [Q_W-1:0]    pop_q;
    logic [IDX_W-1:0]  pop_idx;
    logic [QUEUES-1:0] q_valid;
    logic [IDX_W-1:0]  free_count;
    logic              next_w_en;
    logic [IDX_W-1:0]  next_w_addr;
    logic [IDX_W-1:0]  next_w_data;
    logic              next_r_en;
    logic [IDX_W-1:0]  next_r_addr;
    logic [IDX_W-1:0]  next_r_data;

    logic [IDX_W-1:0] ram [64];

    int checks = 0;
    int errors = 0;

    list_buffer_ctrl #(
        .ENTRIES(ENTRIES), .IDX_W(IDX_W), .QUEUES(QUEUES), .Q_W(Q_W)
    ) dut (
        .clock(clock), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready), .push_q(push_q), .push_idx(push_idx),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_q(pop_q), .pop_idx(pop_idx),
        .q_valid(q_valid), .free_count(free_count),
        .next_w_en(next_w_en), .next_w_addr(next_w_addr), .next_w_data(next_w_data),
        .next_r_en(next_r_en), .next_r_addr(next_r_addr), .next_r_data(next_r_data)
    );

    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = '0;
    end

    always @(posedge clock) begin
        if (next_w_en) ram[next_w_addr] <= next_w_data;
    end

    assign next_r_data = ram[next_r_addr];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic pv, input int pq, input logic ov, input int oq);
        push_valid = pv;
        push_q     = Q_W'(pq);
        pop_valid  = ov;
        pop_q      = Q_W'(oq);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 0, 1'b0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 0, 1'b0, 0);
        checks++; if (q_valid !== 4'b0000) begin errors++; $display("FAIL reset_q_valid got %b exp 0000", q_valid); end
        checks++; if (free_count !== 6'd33) begin errors++; $display("FAIL reset_free_count got %0d exp 33", free_count); end
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready got %b exp 1", push_ready); end
        checks++; if (pop_ready !== 1'b0) begin errors++; $display("FAIL reset_pop_ready got %b exp 0", pop_ready); end
        checks++; if (next_w_en !== 1'b0) begin errors++; $display("FAIL reset_next_w_en got %b exp 0", next_w_en); end
        checks++; if (push_idx !== 6'd0) begin errors++; $display("FAIL reset_push_idx got %0d exp 0", push_idx); end
    endtask

    task automatic test_push_three();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 0, 1'b0, 0);
            checks++; if (push_idx !== IDX_W'(i)) begin errors++; $display("FAIL push3_idx[%0d] got %0d exp %0d", i, push_idx, i); end
            checks++; if (next_w_en !== (i > 0)) begin errors++; $display("FAIL push3_w_en[%0d] got %b exp %b", i, next_w_en, i > 0); end
            if (i > 0) begin
                checks++; if (next_w_addr !== IDX_W'(i - 1) || next_w_data !== IDX_W'(i)) begin
                    errors++; $display("FAIL push3_write[%0d] got %0d<-%0d exp %0d<-%0d", i, next_w_addr, next_w_data, i - 1, i);
                end
            end
            tick();
        end
        drive(1'b0, 0, 1'b0, 0);
        checks++; if (q_valid !== 4'b0001) begin errors++; $display("FAIL push3_q_valid got %b exp 0001", q_valid); end
        checks++; if (free_count !== 6'd30) begin errors++; $display("FAIL push3_free_count got %0d exp 30", free_count); end
    endtask

    task automatic test_pop_three();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 0, 1'b1, 0);
            checks++; if (pop_ready !== 1'b1) begin errors++; $display("FAIL pop3_ready[%0d] got %b exp 1", i, pop_ready); end
            checks++; if (pop_idx !== IDX_W'(i)) begin errors++; $display("FAIL pop3_idx[%0d] got %0d exp %0d", i, pop_idx, i); end
            checks++; if (next_r_en !== 1'b1 || next_r_addr !== IDX_W'(i)) begin
                errors++; $display("FAIL pop3_read[%0d] got en=%b addr=%0d exp en=1 addr=%0d", i, next_r_en, next_r_addr, i);
            end
            tick();
        end
        drive(1'b0, 0, 1'b0, 0);
        checks++; if (q_valid !== 4'b0000) begin errors++; $display("FAIL pop3_q_valid got %b exp 0000", q_valid); end
        checks++; if (free_count !== 6'd33) begin errors++; $display("FAIL pop3_free_count got %0d exp 33", free_count); end
        checks++; if (push_idx !== 6'd0) begin errors++; $display("FAIL pop3_next_push_idx got %0d exp 0", push_idx); end
        checks++; if (pop_ready !== 1'b0) begin errors++; $display("FAIL pop3_pop_ready got %b exp 0", pop_ready); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 33; i++) begin
            drive(1'b1, i % 4, 1'b0, 0);
            checks++; if (push_idx !== IDX_W'(i)) begin errors++; $display("FAIL full_idx[%0d] got %0d exp %0d", i, push_idx, i); end
            checks++; if (next_w_en !== (i >= 4)) begin errors++; $display("FAIL full_w_en[%0d] got %b exp %b", i, next_w_en, i >= 4); end
            if (i >= 4) begin
                checks++; if (next_w_addr !== IDX_W'(i - 4)) begin errors++; $display("FAIL full_w_addr[%0d] got %0d exp %0d", i, next_w_addr, i - 4); end
            end
            tick();
        end
        drive(1'b1, 1, 1'b0, 0);
        checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL full_push_ready got %b exp 0", push_ready); end
        checks++; if (next_w_en !== 1'b0) begin errors++; $display("FAIL full_blocked_w_en got %b exp 0", next_w_en); end
        tick();
        drive(1'b0, 0, 1'b0, 0);
        checks++; if (free_count !== 6'd0) begin errors++; $display("FAIL full_free_count got %0d exp 0", free_count); end
        checks++; if (q_valid !== 4'b1111) begin errors++; $display("FAIL full_q_valid got %b exp 1111", q_valid); end
        drive(1'b0, 0, 1'b1, 1);
        checks++; if (pop_idx !== 6'd1) begin errors++; $display("FAIL full_pop_idx got %0d exp 1", pop_idx); end
        tick();
        drive(1'b0, 0, 1'b0, 0);
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL full_reopen_ready got %b exp 1", push_ready); end
        checks++; if (push_idx !== 6'd1) begin errors++; $display("FAIL full_reopen_idx got %0d exp 1", push_idx); end
        checks++; if (free_count !== 6'd1) begin errors++; $display("FAIL full_reopen_count got %0d exp 1", free_count); end
        drive(1'b0, 0, 1'b1, 1);
        checks++; if (pop_idx !== 6'd5) begin errors++; $display("FAIL full_q1_next_head got %0d exp 5", pop_idx); end
    endtask

    task automatic test_same_queue();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 0, 1'b0, 0);
            tick();
        end
        drive(1'b1, 2, 1'b0, 0);
        tick();
        drive(1'b1, 2, 1'b1, 2);
        checks++; if (push_idx !== 6'd6 || pop_idx !== 6'd5) begin
            errors++; $display("FAIL same1_idx got push=%0d pop=%0d exp push=6 pop=5", push_idx, pop_idx);
        end
        checks++; if (next_w_en !== 1'b0) begin errors++; $display("FAIL same1_w_en got %b exp 0", next_w_en); end
        tick();
        drive(1'b0, 0, 1'b0, 2);
        checks++; if (q_valid !== 4'b0101) begin errors++; $display("FAIL same1_q_valid got %b exp 0101", q_valid); end
        checks++; if (free_count !== 6'd27) begin errors++; $display("FAIL same1_free_count got %0d exp 27", free_count); end
        checks++; if (pop_idx !== 6'd6) begin errors++; $display("FAIL same1_head got %0d exp 6", pop_idx); end
        drive(1'b0, 0, 1'b1, 2);
        tick();
        drive(1'b0, 0, 1'b0, 0);
        checks++; if (q_valid !== 4'b0001) begin errors++; $display("FAIL same1_drain got %b exp 0001", q_valid); end
        checks++; if (push_idx !== 6'd5) begin errors++; $display("FAIL same1_freed_slot got %0d exp 5", push_idx); end
        drive(1'b1, 0, 1'b1, 0);
        checks++; if (next_w_en !== 1'b1 || next_w_addr !== 6'd4 || next_w_data !== 6'd5) begin
            errors++; $display("FAIL samen_write got en=%b %0d<-%0d exp en=1 4<-5", next_w_en, next_w_addr, next_w_data);
        end
        checks++; if (next_r_addr !== 6'd0 || pop_idx !== 6'd0) begin
            errors++; $display("FAIL samen_read got addr=%0d pop=%0d exp 0", next_r_addr, pop_idx);
        end
        tick();
        drive(1'b0, 0, 1'b0, 0);
        checks++; if (free_count !== 6'd28) begin errors++; $display("FAIL samen_free_count got %0d exp 28", free_count); end
        checks++; if (push_idx !== 6'd0) begin errors++; $display("FAIL samen_push_idx got %0d exp 0", push_idx); end
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 0, 1'b1, 0);
            checks++; if (pop_idx !== IDX_W'(i)) begin errors++; $display("FAIL samen_order[%0d] got %0d exp %0d", i, pop_idx, i); end
            tick();
        end
        drive(1'b0, 0, 1'b0, 0);
        checks++; if (q_valid !== 4'b0000) begin errors++; $display("FAIL samen_empty got %b exp 0000", q_valid); end
    endtask

    task automatic test_interleave();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, (i % 2 == 0) ? 0 : 3, 1'b0, 0);
            if (i >= 2) begin
                checks++; if (next_w_en !== 1'b1 || next_w_addr !== IDX_W'(i - 2) || next_w_data !== IDX_W'(i)) begin
                    errors++; $display("FAIL ilv_write[%0d] got en=%b %0d<-%0d exp en=1 %0d<-%0d", i, next_w_en, next_w_addr, next_w_data, i - 2, i);
                end
            end
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 0, 1'b1, (i % 2 == 0) ? 0 : 3);
            checks++; if (pop_idx !== IDX_W'(i)) begin errors++; $display("FAIL ilv_pop[%0d] got %0d exp %0d", i, pop_idx, i); end
            tick();
        end
        drive(1'b0, 0, 1'b0, 0);
        checks++; if (q_valid !== 4'b0000 || free_count !== 6'd33) begin
            errors++; $display("FAIL ilv_final got q=%b cnt=%0d exp q=0000 cnt=33", q_valid, free_count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i, 1'b0, 0);
            tick();
        end
        drive(1'b0, 0, 1'b0, 0);
        checks++; if (q_valid !== 4'b1111) begin errors++; $display("FAIL rmid_pre got %b exp 1111", q_valid); end
        drive(1'b1, 0, 1'b1, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 0, 1'b0, 0);
        checks++; if (q_valid !== 4'b0000) begin errors++; $display("FAIL rmid_q_valid got %b exp 0000", q_valid); end
        checks++; if (free_count !== 6'd33) begin errors++; $display("FAIL rmid_free_count got %0d exp 33", free_count); end
        checks++; if (push_idx !== 6'd0) begin errors++; $display("FAIL rmid_push_idx got %0d exp 0", push_idx); end
        for (int q = 0; q < 4; q++) begin
            drive(1'b0, 0, 1'b0, q);
            checks++; if (pop_ready !== 1'b0) begin errors++; $display("FAIL rmid_pop_ready[%0d] got %b exp 0", q, pop_ready); end
        end
    endtask

    initial begin
        reset      = 1'b1;
        push_valid = 1'b0;
        push_q     = '0;
        pop_valid  = 1'b0;
        pop_q      = '0;
        tick();
        test_reset();
        test_push_three();
        test_pop_three();
        test_full();
        test_same_queue();
        test_interleave();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
